// File: rtl/suma_ctrl.sv
// Button-driven accumulate sequencer: debounce, add dipswitch into a 0..ACC_MAX
// accumulator, double-dabble to BCD. Define SUMA_SATURATE_EN to clamp instead of wrap.
module suma_ctrl #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int ACC_MAX         = 9999
) (
    input  logic        clk_pi,
    input  logic        rst_n_pi,
    input  logic [3:0]  dipswitch,
    input  logic        suma_btn,
    output logic [15:0] acumulador_total,
    output logic [15:0] bcd_po,
    output logic        bcd_valid_po,
    output logic        busy_po,
    output logic        overflow_po,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DD_ITERS = 14;

    typedef enum logic [1:0] {IDLE, ADD, CONV, LOAD} state_t;

    state_t            state, state_nxt;
    logic              btn_s1, btn_s2, btn_db, btn_db_q, add_req;
    logic [3:0]        dip_s1, dip_s2, addend;
    logic [CNT_W-1:0]  db_cnt;
    logic [29:0]       shift_sr, dd_next;
    logic [3:0]        iter;
    logic [16:0]       sum17;
    logic              sum_over;
    logic [15:0]       sum_fix;

    // Input synchronisers for the button and the addend switches.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            dip_s1 <= '0;
            dip_s2 <= '0;
        end else begin
            btn_s1 <= suma_btn;
            btn_s2 <= btn_s1;
            dip_s1 <= dipswitch;
            dip_s2 <= dip_s1;
        end
    end

    // Handshake: add_req is a one-cycle strobe with no ready; the FSM consumes it
    // only in IDLE and any strobe arriving in another state is simply lost.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            add_req  <= 1'b0;
        end else begin
            if (btn_s2 != btn_db) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            btn_db_q <= btn_db;
            add_req  <= btn_db & ~btn_db_q;
        end
    end

    function automatic logic [29:0] dd_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5)
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    always_comb begin
        dd_next  = dd_step(shift_sr);
        sum17    = {1'b0, acumulador_total} + {13'd0, addend};
        sum_over = (sum17 > 17'(ACC_MAX));
        sum_fix  = sum17[15:0];
        if (sum_over) begin
`ifdef SUMA_SATURATE_EN
            sum_fix = 16'(ACC_MAX);
`else
            sum_fix = 16'(sum17 - 17'(ACC_MAX + 1));
`endif
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (add_req) state_nxt = ADD;
            ADD:     state_nxt = CONV;
            CONV:    if (iter == 4'(DD_ITERS - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_po      = (state != IDLE);
        bcd_valid_po = (state == LOAD);
        state_dbg    = state;
    end

    // bcd_po is written on the last CONV cycle so the new digits coincide with the LOAD pulse.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            addend           <= '0;
            acumulador_total <= '0;
            overflow_po      <= 1'b0;
            shift_sr         <= '0;
            iter             <= '0;
            bcd_po           <= '0;
        end else begin
            unique case (state)
                IDLE: if (add_req) addend <= dip_s2;
                ADD: begin
                    acumulador_total <= sum_fix;
                    overflow_po      <= overflow_po | sum_over;
                    shift_sr         <= {16'd0, sum_fix[13:0]};
                    iter             <= '0;
                end
                CONV: begin
                    shift_sr <= dd_next;
                    iter     <= iter + 4'd1;
                    if (iter == 4'(DD_ITERS - 1)) bcd_po <= dd_next[29:14];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/suma_ctrl.md
# suma_ctrl

Sequencer for the adder datapath: it turns the `suma_btn` push into one accumulate operation and updates the display. It synchronises and debounces the button, then samples `dipswitch` on each accepted press. It adds that value into a 4-digit decimal accumulator, converts the result to BCD with an iterative double-dabble, and hands the digits to the display multiplexer. It sits between the board inputs and the seven-segment driver in the top level.

## Interface
- `DEBOUNCE_CYCLES`, 270000: cycles the synchronised button must be stable before its level is accepted (10 ms at 27 MHz).
- `ACC_MAX`, 9999: largest accumulator value; four decimal digits.
- `clk_pi` input 1: system clock, 27 MHz.
- `rst_n_pi` input 1: reset; one clock; reset is asynchronous and active-low.
- `dipswitch` input 4: addend, unsigned 0–15, asynchronous to the clock.
- `suma_btn` input 1: raw push button, active-high, bouncy.
- `acumulador_total` output 16: binary accumulator value, 0..ACC_MAX.
- `bcd_po` output 16: four BCD digits; [15:12] thousands … [3:0] units.
- `bcd_valid_po` output 1: one-cycle pulse when `bcd_po` is updated.
- `busy_po` output 1: high while an operation is in progress.
- `overflow_po` output 1: sticky flag; set when a sum exceeded ACC_MAX; cleared only by reset.

## Operation
- Button path:
  - 2-flop synchroniser, then debounce counter.
  - The counter reloads on any change of the synchronised level.
  - When the level has been stable for DEBOUNCE_CYCLES cycles, it is copied to `btn_db`.
  - The rising edge of `btn_db` produces the one-cycle `add_req`.
- `dipswitch` also passes through a 2-flop synchroniser.
- Its synchronised value is captured in the cycle `add_req` is seen in IDLE.
- FSM states:
  - IDLE: on `add_req`, capture the addend and go to ADD. Otherwise stay.
  - ADD: compute `acumulador_total` + addend in 17 bits and apply the overflow rule (see Configuration). Register the result into `acumulador_total`, load the shift register, go to CONV.
  - CONV: 14 double-dabble iterations, one per cycle. In each iteration, every BCD nibble ≥5 gets +3, then shift left by one. After iteration 14, go to LOAD.
  - LOAD: copy the BCD result to `bcd_po`, pulse `bcd_valid_po`, return to IDLE.
- `busy_po` = 1 in ADD, CONV and LOAD; 0 in IDLE.
- `add_req` arriving while not in IDLE is dropped. It is not queued. A press needs a release, then a new debounced rising edge.
- A glitch shorter than DEBOUNCE_CYCLES never changes `btn_db`.
- Addend 0 still runs the full sequence and pulses `bcd_valid_po`.

## Timing
- Reset values: `acumulador_total`=0, `bcd_po`=0, `bcd_valid_po`=0, `busy_po`=0, `overflow_po`=0.
  - FSM=IDLE, `btn_db`=0, debounce counter=0, synchronisers=0.
- Press to request: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles from the `suma_btn` rise to `add_req`.
- Let `add_req` be seen in IDLE at cycle N. Then:
  - ADD is cycle N+1, and `acumulador_total` changes at the end of N+1.
  - CONV covers cycles N+2..N+15.
  - LOAD is cycle N+16: `bcd_po` updates and `bcd_valid_po`=1 for exactly that cycle.
  - IDLE again at N+17.
- `busy_po` is high for cycles N+1..N+16, which is 16 cycles.
- `bcd_po` holds its previous value throughout the operation.
- Reset asserted mid-operation clears everything immediately; no partial update survives.
  - If the button is still held after reset release, it is accepted as a new press once DEBOUNCE_CYCLES elapse.

## Configuration
- `SUMA_SATURATE_EN` defined: a sum > ACC_MAX clamps to ACC_MAX (9999) and sets `overflow_po`.
- Not defined (default): a sum > ACC_MAX wraps to sum − (ACC_MAX+1) and sets `overflow_po`.
  - Example: 9995 + 7 → 2.
- In both modes, a sum == ACC_MAX exactly does not set `overflow_po`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then 1-cycle `suma_btn` glitches with `dipswitch`=5 → `acumulador_total` stays 0, no `bcd_valid_po`.
- Press held 20 cycles, `dipswitch`=1; then 2, 4, 8, 5 in turn → `acumulador_total` = 1, 3, 7, 15, 20; `bcd_po`=0x0020.
  - `busy_po` is 16 cycles wide per press, and `bcd_valid_po` pulses 16 cycles after `add_req`.
- Second press released and re-pressed while `busy_po`=1 (pressed 1 cycle after `add_req`, `dipswitch`=3) → dropped.
  - Accumulator grows by the first addend only.
- Start at 9990, add 9 → 9999, `overflow_po`=0; then add 7:
  - Default build → 6, `bcd_po`=0x0006, `overflow_po`=1.
  - `SUMA_SATURATE_EN` build → 9999, `bcd_po`=0x9999, `overflow_po`=1.
- `rst_n_pi` low for 1 cycle during CONV (accumulator 42 → 57) → all outputs 0 at once.
  - After release with the button held, one new press is accepted and the accumulator equals the `dipswitch` value.
